// File: rtl/seq_mult_unit.sv
// seq_mult_unit
// Parametrised multi-cycle multiplier: one shift-add (unsigned) or radix-2
// Booth (signed) iteration per clock, WIDTH iterations per product.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   reset        - synchronous active-high reset
//   run          - start request, sampled only in IDLE or DONE
//   signed_mode  - 1: two's-complement operands/product, 0: unsigned (latched at start)
//   multiplicand - operand M (latched at start)
//   multiplier   - operand Q (latched at start)
//   busy         - iterations in progress
//   ready        - product holds a completed result
//   product      - 2*WIDTH-bit result register, updated only on completion
module seq_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   q_reg, q_nx;
  logic [WIDTH:0]     a_reg, a_nx;
  logic [WIDTH:0]     m_ext, sum;
  logic               mode_reg;
  logic               qm1, qm1_nx;
  logic [CNT_W-1:0]   cnt;
  logic               start, last;

  // One iteration of the datapath. The accumulator is one bit wider than the
  // operands so that the add never overflows (unsigned carry) and so that
  // -2^(W-1) * -2^(W-1) keeps its correct sign during Booth subtraction.
  always_comb begin
    m_ext  = mode_reg ? {m_reg[WIDTH-1], m_reg} : {1'b0, m_reg};
    sum    = a_reg;
    if (mode_reg) begin
      case ({q_reg[0], qm1})
        2'b01:   sum = a_reg + m_ext;
        2'b10:   sum = a_reg - m_ext;
        default: sum = a_reg;
      endcase
    end else if (q_reg[0]) begin
      sum = a_reg + m_ext;
    end
    // Signed mode shifts arithmetically (A[WIDTH] replicated), unsigned logically.
    a_nx   = {(mode_reg & sum[WIDTH]), sum[WIDTH:1]};
    q_nx   = {sum[0], q_reg[WIDTH-1:1]};
    qm1_nx = q_reg[0];
  end

  // Next-state and control decode.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    last     = (cnt == CNT_W'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (run) begin
          start    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (run) begin
          start    = 1'b1;
          state_nx = BUSY;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == BUSY);
    ready = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_reg    <= '0;
      q_reg    <= '0;
      a_reg    <= '0;
      mode_reg <= 1'b0;
      qm1      <= 1'b0;
      cnt      <= '0;
      product  <= '0;
    end else if (start) begin
      m_reg    <= multiplicand;
      q_reg    <= multiplier;
      a_reg    <= '0;
      mode_reg <= signed_mode;
      qm1      <= 1'b0;
      cnt      <= '0;
    end else if (state == BUSY) begin
      a_reg <= a_nx;
      q_reg <= q_nx;
      qm1   <= qm1_nx;
      cnt   <= cnt + CNT_W'(1);
      if (last) product <= {a_nx[WIDTH-1:0], q_nx};
    end
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Testbench for seq_mult_unit: three instances (WIDTH 8, 16, 32) share clock
// and reset. Expected products are queued when an operation is started and
// compared when the matching ready pulse appears.
module tb_seq_mult_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_v  [3];
  logic        sm_v   [3];
  logic [63:0] mc_v   [3];
  logic [63:0] mp_v   [3];
  logic        busy_v [3];
  logic        ready_v[3];
  logic [63:0] prod_v [3];
  logic [15:0] p8;
  logic [31:0] p16;
  logic [63:0] p32;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  logic        prev_busy [3];
  logic        prev_ready[3];
  logic [63:0] prev_prod [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_mult_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .run(run_v[0]), .signed_mode(sm_v[0]),
    .multiplicand(mc_v[0][7:0]), .multiplier(mp_v[0][7:0]),
    .busy(busy_v[0]), .ready(ready_v[0]), .product(p8)
  );

  seq_mult_unit #(.WIDTH(16)) u_w16 (
    .clk(clk), .reset(reset), .run(run_v[1]), .signed_mode(sm_v[1]),
    .multiplicand(mc_v[1][15:0]), .multiplier(mp_v[1][15:0]),
    .busy(busy_v[1]), .ready(ready_v[1]), .product(p16)
  );

  seq_mult_unit #(.WIDTH(32)) u_w32 (
    .clk(clk), .reset(reset), .run(run_v[2]), .signed_mode(sm_v[2]),
    .multiplicand(mc_v[2][31:0]), .multiplier(mp_v[2][31:0]),
    .busy(busy_v[2]), .ready(ready_v[2]), .product(p32)
  );

  always_comb begin
    prod_v[0] = {48'd0, p8};
    prod_v[1] = {32'd0, p16};
    prod_v[2] = p32;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 16 : 32);
  endfunction

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: native multiply on sign- or zero-extended operands.
  function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                          input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    logic [63:0] r;
    if (sm) begin
      sa = longint'(a << (64 - w)) >>> (64 - w);
      sb = longint'(b << (64 - w)) >>> (64 - w);
      r  = sa * sb;
    end else begin
      r = (a & mask(w)) * (b & mask(w));
    end
    return r & mask(2 * w);
  endfunction

  function automatic void sb_push(input int i, input logic [63:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int sb_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [63:0] sb_pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor: scoreboard compare on each ready rise, product stability in
  // BUSY and DONE, and busy/ready exclusivity.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        check("busy_ready_excl", 64'(busy_v[i] & ready_v[i]), 64'd0);
        if (busy_v[i])
          check("product_hold_busy", prod_v[i], prev_prod[i]);
        if (ready_v[i] && prev_ready[i])
          check("product_hold_done", prod_v[i], prev_prod[i]);
        if (ready_v[i] && !prev_ready[i]) begin
          if (sb_size(i) == 0)
            check("sb_underflow", 64'(sb_size(i)), 64'd1);
          else
            check("product", prod_v[i], sb_pop(i));
        end
      end
      prev_busy[i]  = busy_v[i];
      prev_ready[i] = ready_v[i];
      prev_prod[i]  = prod_v[i];
    end
  end

  task automatic wait_ready(input int i, input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready_v[i] && n < bound);
    check("wait_ready", 64'(ready_v[i]), 64'd1);
  endtask

  // Start one operation with a run pulse and wait for its result. With
  // scramble set, mode/operands/run are disturbed while the unit is busy.
  task automatic run_op(input int i, input bit sm, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input bit scramble);
    int w, n;
    w = wid(i);
    @(negedge clk);
    run_v[i] = 1'b1;
    sm_v[i]  = sm;
    mc_v[i]  = a & mask(w);
    mp_v[i]  = b & mask(w);
    sb_push(i, exp);
    @(posedge clk); #1;
    check("busy_at_start", 64'(busy_v[i]), 64'd1);
    run_v[i] = scramble;
    if (scramble) begin
      sm_v[i] = ~sm;
      mc_v[i] = {$urandom, $urandom} & mask(w);
      mp_v[i] = {$urandom, $urandom} & mask(w);
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 2) run_v[i] = 1'b0;
      if (!ready_v[i]) check("busy_hold", 64'(busy_v[i]), 64'd1);
    end while (!ready_v[i] && n < w + 4);
    check("latency", 64'(n), 64'(w));
  endtask

  function automatic logic [63:0] rnd_operand(input int w);
    logic [63:0] m;
    m = mask(w);
    case ($urandom_range(0, 11))
      0:       return 64'd0;
      1:       return m;
      2:       return 64'd1 << (w - 1);
      3:       return m >> 1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic sweep(input int i, input int count);
    int          w;
    bit          sm;
    logic [63:0] a, b;
    w = wid(i);
    for (int k = 0; k < count; k++) begin
      sm = 1'($urandom_range(0, 1));
      a  = rnd_operand(w);
      b  = rnd_operand(w);
      run_op(i, sm, a, b, ref_mul(w, sm, a, b), $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, t1, t2;
    for (int i = 0; i < 3; i++) begin
      run_v[i]      = 1'b0;
      sm_v[i]       = 1'b0;
      mc_v[i]       = '0;
      mp_v[i]       = '0;
      prev_busy[i]  = 1'b0;
      prev_ready[i] = 1'b0;
      prev_prod[i]  = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_busy", 64'(busy_v[i]), 64'd0);
      check("reset_ready", 64'(ready_v[i]), 64'd0);
      check("reset_product", prod_v[i], 64'd0);
    end
    reset = 1'b0;

    // Unsigned maximum, WIDTH=8
    run_op(0, 1'b0, 64'd255, 64'd255, 64'h0000_0000_0000_FE01, 1'b0);

    // Signed corners, WIDTH=8
    run_op(0, 1'b1, 64'h80, 64'h80, 64'h4000, 1'b0);
    run_op(0, 1'b1, 64'h80, 64'h7F, 64'hC080, 1'b0);
    run_op(0, 1'b1, 64'hFF, 64'h01, 64'hFFFF, 1'b0);
    run_op(0, 1'b1, 64'h00, 64'hFB, 64'h0000, 1'b0);
    // Unsigned view of the same bit pattern as -1 x 1
    run_op(0, 1'b0, 64'hFF, 64'h01, 64'h00FF, 1'b0);

    // Reset during BUSY: no partial result, all outputs cleared
    @(negedge clk);
    run_v[0] = 1'b1; sm_v[0] = 1'b0; mc_v[0] = 64'd200; mp_v[0] = 64'd3;
    @(posedge clk); #1;
    run_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_busy", 64'(busy_v[0]), 64'd0);
    check("midreset_ready", 64'(ready_v[0]), 64'd0);
    check("midreset_product", prod_v[0], 64'd0);
    run_op(0, 1'b0, 64'd7, 64'd6, 64'd42, 1'b0);

    // Mode/operand/run changes while busy are ignored, WIDTH=32
    run_op(2, 1'b1, 64'd3, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);

    // Back-to-back with run held high, WIDTH=16
    @(negedge clk);
    run_v[1] = 1'b1; sm_v[1] = 1'b0; mc_v[1] = 64'd1000; mp_v[1] = 64'd1000;
    sb_push(1, 64'd1_000_000);
    @(posedge clk); #1;
    mc_v[1] = 64'd65535; mp_v[1] = 64'd2;
    sb_push(1, 64'd131070);
    wait_ready(1, 40, n);
    t1 = int'(cyc);
    @(posedge clk); #1;
    check("b2b_ready_pulse", 64'(ready_v[1]), 64'd0);
    check("b2b_restart_busy", 64'(busy_v[1]), 64'd1);
    run_v[1] = 1'b0;
    wait_ready(1, 40, n);
    t2 = int'(cyc);
    check("b2b_spacing", 64'(t2 - t1), 64'd17);

    // Random sweep, all widths concurrently
    fork
      sweep(0, 5000);
      sweep(1, 3000);
      sweep(2, 2000);
    join

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check("sb_leftover", 64'(sb_size(i)), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_unit.md
# seq_mult_unit

Parametrised sequential multiplier: controller plus datapath in one block, successor to the fixed 32-bit shift-add control. Computes one exact 2·WIDTH-bit product of two WIDTH-bit operands, one iteration per clock. Supports unsigned (shift-add) and two's-complement signed (radix-2 Booth) modes, selected per operation. Sits beside the ALU as the multi-cycle multiply resource, driven by a run/ready handshake.

## Interface
- WIDTH, 32, operand width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- run  in  1  start request; sampled only in IDLE or DONE.
- signed_mode  in  1  1 = two's-complement operands and product, 0 = unsigned; latched at start.
- multiplicand  in  WIDTH  operand M; latched at start.
- multiplier  in  WIDTH  operand Q; latched at start.
- busy  out  1  high while iterations are in progress.
- ready  out  1  high while product holds a completed result.
- product  out  2·WIDTH  result register.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: busy=0, ready=0. run=1 → load, go to BUSY.
- Load: M and mode latched; accumulator A (WIDTH+1 bits) = 0; Q register = multiplier; Booth bit q_m1 = 0; counter = 0.
- BUSY, one iteration per cycle, exactly WIDTH iterations:
  - Unsigned: if Q[0]=1, A = A + {0,M} (carry kept in A[WIDTH]). Then logical right shift of {A,Q} by one.
  - Signed: {Q[0],q_m1}=01 → A = A + sext(M); 10 → A = A − sext(M); 00/11 → no add. Then arithmetic right shift of {A,Q,q_m1} by one, with A[WIDTH] replicated.
  - counter increments each iteration. When the WIDTH-th iteration completes: product = {A[WIDTH-1:0], Q}, go to DONE.
- DONE: ready=1, busy=0, product stable. run=1 → load new operands, go to BUSY; ready drops on that edge. run=0 → stay in DONE indefinitely.
- product changes only on the completion edge and on reset. It holds the previous result through BUSY.
- Arithmetic: the result is exact for all operand pairs.
  - Unsigned max: (2^W−1)² fits in 2W bits.
  - Signed (−2^(W−1))·(−2^(W−1)) = +2^(2W−2) must be produced correctly. The WIDTH+1-bit accumulator makes this hold.
- run, signed_mode and operand changes during BUSY are ignored.
- Reset wins over everything, including a completion edge and run=1.

## Timing
- Reset values: busy=0, ready=0, product=0, state IDLE, counter=0.
- run=1 sampled at edge k (state IDLE or DONE):
  - busy=1 from edge k.
  - Iterations happen on edges k+1 … k+WIDTH.
  - At edge k+WIDTH: busy=0, ready=1, product valid.
- Latency: WIDTH cycles from the start edge to ready. Throughput: one product per WIDTH+1 cycles when run is held high, because DONE re-samples run on the cycle after completion.
- busy and ready are never both 1. Exactly one of IDLE, BUSY or DONE is active.
- Reset asserted during BUSY: next edge returns to IDLE and clears product. A partial result is never exposed.
- run held high continuously: back-to-back operations. ready pulses high for exactly one cycle per result.

## Test plan
- Reset mid-op (WIDTH=8): start 200×3 unsigned, assert reset after 4 iterations → next cycle busy=0, ready=0, product=0; a fresh start of 7×6 gives 42.
- Unsigned max (WIDTH=8): M=255, Q=255, signed_mode=0, run pulse at edge k → ready=1 at edge k+8, product=16'hFE01. busy=1 for edges k..k+7.
- Signed corners (WIDTH=8): −128×−128 → 16'h4000; −128×127 → 16'hC080; −1×1 → 16'hFFFF; 0×−5 → 0.
- Mode/operand change mid-op (WIDTH=32): start 3×−2 signed, flip signed_mode and operands during BUSY → product=64'hFFFF_FFFF_FFFF_FFFA at edge k+32; inputs ignored.
- Back-to-back (WIDTH=16): run held high, operand pairs 1000×1000 then 65535×2 unsigned → products 1_000_000 then 131070. ready high one cycle each; starts 17 cycles apart.
- Random sweep (WIDTH=8, 16, 32): 10k random operand pairs in both modes against a reference multiply. The bench also checks that product stays constant through BUSY and that busy and ready are mutually exclusive.
